clause_output_packer: RTL and testbench
=======================================

CLAUSE_OUTPUT_PACKER -- requirements
Module: clause_output_packer

Interface
REQ-001 SHALL have parameter INT_SIZE, default 32, meaning the packed word width in bits; must be a power of 2, at least 8.
REQ-002 SHALL have parameter CLAUSE_CHUNKS, default 63, meaning the number of valid chunk words.
REQ-003 SHALL have parameter IDX_W, default 17, meaning the clause index width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning the output FIFO entries; must be a power of 2, at least 2.
REQ-005 SHALL use one clock and a synchronous active-high reset, ports as follows:
- clk  in  1  clock, rising edge.
- rst_flag  in  1  synchronous, active-high reset.
- stop_flag  in  1  freeze: no input accept and no accumulator or FIFO write; FIFO read is still allowed.
- predict_mode  in  1  1 = inference; suppress all-excluded clauses.
- cmp_valid  in  1  comparator result valid.
- cmp_ready  out  1  packer accepts a result.
- cmp_index  in  IDX_W  clause index.
- cmp_fire  in  1  clause output bit.
- cmp_empty  in  1  clause has no included literals.
- flush  in  1  push the partial accumulator to the FIFO.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head.
- out_chunk  out  CW=clog2(CLAUSE_CHUNKS)  chunk number of the head.
- out_word  out  INT_SIZE  bitmap of firing clauses in the chunk.
- last_chunk  out  32  chunk of the latest accepted hit.
- last_pos  out  32  bit position of the latest accepted hit.
- range_err  out  1  sticky: a hit had chunk >= CLAUSE_CHUNKS.

Function
REQ-006 An input is accepted when cmp_valid && cmp_ready.
- cmp_ready = !stop_flag && !flush && (fifo_count < FIFO_DEPTH-1 || state==IDLE).
REQ-007 hit = accepted && cmp_fire && !(predict_mode && cmp_empty); a non-hit acceptance changes no state.
REQ-008 Index split: chunk = cmp_index >> log2(INT_SIZE); pos = cmp_index & (INT_SIZE-1).
- last_chunk and last_pos are zero-extended to 32 bits.
- They update the cycle after every hit, including out-of-range hits.
REQ-009 A hit with chunk >= CLAUSE_CHUNKS sets range_err and does not touch the accumulator.
REQ-010 The state machine has states IDLE (accumulator empty) and ACCUM (holds acc_chunk, acc_word).
REQ-011 IDLE + in-range hit -> ACCUM; acc_chunk = chunk; acc_word = one-hot(pos).
REQ-012 ACCUM + hit with chunk == acc_chunk: acc_word |= one-hot(pos); the state stays ACCUM.
- A repeated pos is idempotent.
REQ-013 ACCUM + in-range hit with chunk != acc_chunk, higher or lower: push {acc_chunk, acc_word} to the FIFO, then restart the accumulator with the new hit, all in the same cycle.
REQ-014 flush && !stop_flag in ACCUM: push the accumulator and go to IDLE; flush in IDLE does nothing.
- flush has priority: cmp_ready is low that cycle.
REQ-015 FIFO behaviour:
- First-word fall-through.
- out_valid = (count != 0); pop on out_valid && out_ready.
- A push and a pop in the same cycle keep the count unchanged.
- The pointers wrap modulo FIFO_DEPTH.
REQ-016 Latency: hit to the word visible on out_* is 1 cycle after the push event (flush or chunk change).
REQ-017 A FIFO push never occurs when full; REQ-006 guarantees this, and an assertion checks it.
REQ-018 stop_flag holds the accumulator, range_err and last_* unchanged; pops are still honoured.

Reset
REQ-019 On rst_flag at a clock edge, the following clear regardless of other inputs, including mid-accumulation:
- state = IDLE.
- acc_chunk, acc_word, FIFO pointers and count = 0.
- out_valid = 0; out_chunk and out_word = 0.
- last_chunk, last_pos and range_err = 0.
REQ-020 cmp_ready is 0 during the reset cycle.
- Pending partial words are discarded.

Structure
REQ-021 A shared package SHALL hold:
- Default INT_SIZE and CLAUSE_CHUNKS.
- The PREDICT/LEARN mode encoding.
- The state enumeration.
- A function for the chunk/pos split, reused by the clause modules.
REQ-022 The FIFO SHALL be one sub-module, sync_fifo_fwft (width CW+INT_SIZE, depth FIFO_DEPTH).

Verification
REQ-023 Hits at indices 3, 7, 31, then flush -> one word: chunk 0, word 0x80000088.
REQ-024 Hits at 5 then 40, with out_ready=1:
- Word chunk 0 = 0x00000020 appears the cycle after the 40 is accepted.
- After a flush, word chunk 1 = 0x00000100.
- last_chunk=1, last_pos=8.
REQ-025 predict_mode=1, index 9, cmp_fire=1, cmp_empty=1 -> no accumulator change; the same with predict_mode=0 sets bit 9.
REQ-026 Hold out_ready=0 and issue hits across chunks 0,1,2,3,4:
- cmp_ready drops when count reaches 3.
- There is no overflow.
- Releasing out_ready yields the words in order.
REQ-027 Hit at index 63*32 = 2016 -> range_err=1 sticky, no FIFO push.
- A reset mid-ACCUM, then a flush -> out_valid stays 0.

Source files
------------

// File: rtl/clause_output_packer_pkg.sv
// rtl/clause_output_packer_pkg.sv - shared defaults, encodings and index split helpers
package clause_output_packer_pkg;

  localparam int DEF_INT_SIZE      = 32;
  localparam int DEF_CLAUSE_CHUNKS = 63;

  typedef enum logic {
    MODE_LEARN   = 1'b0,
    MODE_PREDICT = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Clause index -> (chunk, bit position) for a word of 2**lg bits
  function automatic logic [31:0] idx_chunk(input logic [31:0] idx, input int lg);
    return idx >> lg;
  endfunction

  function automatic logic [31:0] idx_pos(input logic [31:0] idx, input int lg);
    return idx & ((32'd1 << lg) - 32'd1);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - synchronous first-word-fall-through FIFO
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_flag,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [PW:0]      count,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == (PW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && out_valid;
  // Head is forced to zero when empty so stale entries never show after reset
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst_flag) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_flag && push) assert (!full);
  end

endmodule

// File: rtl/clause_output_packer.sv
// rtl/clause_output_packer.sv - packs firing clause indices into per-chunk bitmap words
module clause_output_packer
  import clause_output_packer_pkg::*;
#(
  parameter int INT_SIZE      = DEF_INT_SIZE,
  parameter int CLAUSE_CHUNKS = DEF_CLAUSE_CHUNKS,
  parameter int IDX_W         = 17,
  parameter int FIFO_DEPTH    = 4,
  localparam int CW = $clog2(CLAUSE_CHUNKS),
  localparam int LG = $clog2(INT_SIZE),
  localparam int FW = $clog2(FIFO_DEPTH)
) (
  input  logic                clk,
  input  logic                rst_flag,
  input  logic                stop_flag,
  input  logic                predict_mode,
  input  logic                cmp_valid,
  output logic                cmp_ready,
  input  logic [IDX_W-1:0]    cmp_index,
  input  logic                cmp_fire,
  input  logic                cmp_empty,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       out_chunk,
  output logic [INT_SIZE-1:0] out_word,
  output logic [31:0]         last_chunk,
  output logic [31:0]         last_pos,
  output logic                range_err
);

  state_e              state_q, state_d;
  logic [CW-1:0]       acc_chunk_q, acc_chunk_d;
  logic [INT_SIZE-1:0] acc_word_q, acc_word_d;
  logic                push;
  logic [FW:0]         fifo_count;
  logic                fifo_full;

  logic [31:0]         idx32;
  logic [31:0]         chunk32;
  logic [31:0]         pos32;
  logic [CW-1:0]       chunk;
  logic [INT_SIZE-1:0] onehot;
  logic                in_range;
  logic                accept;
  logic                hit;

  assign idx32    = 32'(cmp_index);
  assign chunk32  = idx_chunk(idx32, LG);
  assign pos32    = idx_pos(idx32, LG);
  assign chunk    = chunk32[CW-1:0];
  assign onehot   = {{(INT_SIZE-1){1'b0}}, 1'b1} << pos32[LG-1:0];
  assign in_range = (chunk32 < 32'(CLAUSE_CHUNKS));

  // One slot is held back in ACCUM so a chunk change always has room to push
  assign cmp_ready = !rst_flag && !stop_flag && !flush &&
                     ((fifo_count < (FW+1)'(FIFO_DEPTH-1)) || (state_q == IDLE));
  assign accept    = cmp_valid && cmp_ready;
  assign hit       = accept && cmp_fire && !((predict_mode == MODE_PREDICT) && cmp_empty);

  always_comb begin
    state_d     = state_q;
    acc_chunk_d = acc_chunk_q;
    acc_word_d  = acc_word_q;
    push        = 1'b0;
    if (flush && !stop_flag) begin
      // A flush against a full FIFO waits in ACCUM rather than overflow
      if (state_q == ACCUM && !fifo_full) begin
        push        = 1'b1;
        state_d     = IDLE;
        acc_chunk_d = '0;
        acc_word_d  = '0;
      end
    end else if (hit && in_range) begin
      if (state_q == IDLE) begin
        state_d     = ACCUM;
        acc_chunk_d = chunk;
        acc_word_d  = onehot;
      end else if (chunk == acc_chunk_q) begin
        acc_word_d  = acc_word_q | onehot;
      end else begin
        push        = 1'b1;
        acc_chunk_d = chunk;
        acc_word_d  = onehot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_flag) begin
      state_q     <= IDLE;
      acc_chunk_q <= '0;
      acc_word_q  <= '0;
      last_chunk  <= '0;
      last_pos    <= '0;
      range_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_chunk_q <= acc_chunk_d;
      acc_word_q  <= acc_word_d;
      if (hit) begin
        last_chunk <= chunk32;
        last_pos   <= pos32;
        if (!in_range) range_err <= 1'b1;
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (CW + INT_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_flag  (rst_flag),
    .push      (push),
    .push_data ({acc_chunk_q, acc_word_q}),
    .pop       (out_valid && out_ready),
    .out_valid (out_valid),
    .out_data  ({out_chunk, out_word}),
    .count     (fifo_count),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_clause_output_packer.sv
// tb/tb_clause_output_packer.sv - directed self-checking bench for clause_output_packer
module tb_clause_output_packer;

  localparam int CW = $clog2(63);

  logic          clk;
  logic          rst_flag;
  logic          stop_flag;
  logic          predict_mode;
  logic          cmp_valid;
  logic          cmp_ready;
  logic [16:0]   cmp_index;
  logic          cmp_fire;
  logic          cmp_empty;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_chunk;
  logic [31:0]   out_word;
  logic [31:0]   last_chunk;
  logic [31:0]   last_pos;
  logic          range_err;

  int checks = 0;
  int errors = 0;

  clause_output_packer dut (
    .clk          (clk),
    .rst_flag     (rst_flag),
    .stop_flag    (stop_flag),
    .predict_mode (predict_mode),
    .cmp_valid    (cmp_valid),
    .cmp_ready    (cmp_ready),
    .cmp_index    (cmp_index),
    .cmp_fire     (cmp_fire),
    .cmp_empty    (cmp_empty),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_chunk    (out_chunk),
    .out_word     (out_word),
    .last_chunk   (last_chunk),
    .last_pos     (last_pos),
    .range_err    (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hit(input int idx);
    cmp_index = idx[16:0];
    cmp_valid = 1'b1;
    cmp_fire  = 1'b1;
    tick();
    cmp_valid = 1'b0;
    cmp_fire  = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_flag  = 1'b1;
    cmp_valid = 1'b1;
    cmp_fire  = 1'b1;
    cmp_index = 17'd3;
    #1;
    checks++;
    if (cmp_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", cmp_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_word !== 32'h0 || out_chunk !== '0) begin
      errors++; $display("FAIL reset_out got v=%b c=%0d w=%h want 0/0/0", out_valid, out_chunk, out_word);
    end
    checks++;
    if (last_chunk !== 32'd0 || last_pos !== 32'd0 || range_err !== 1'b0) begin
      errors++; $display("FAIL reset_last got lc=%0d lp=%0d re=%b want 0/0/0", last_chunk, last_pos, range_err);
    end
    rst_flag  = 1'b0;
    cmp_valid = 1'b0;
    cmp_fire  = 1'b0;
  endtask

  task automatic test_single_chunk();
    out_ready = 1'b0;
    hit(3); hit(7); hit(7); hit(31);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL accum_no_push got %b want 0", out_valid); end
    do_flush();
    checks++;
    if (out_valid !== 1'b1 || out_chunk !== 6'd0 || out_word !== 32'h80000088) begin
      errors++; $display("FAIL flush_word got v=%b c=%0d w=%h want 1/0/80000088", out_valid, out_chunk, out_word);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL pop_empty got %b want 0", out_valid); end
  endtask

  task automatic test_chunk_change();
    out_ready = 1'b1;
    hit(5);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL chg_first got %b want 0", out_valid); end
    hit(40);
    checks++;
    if (out_valid !== 1'b1 || out_chunk !== 6'd0 || out_word !== 32'h00000020) begin
      errors++; $display("FAIL chg_word0 got v=%b c=%0d w=%h want 1/0/00000020", out_valid, out_chunk, out_word);
    end
    do_flush();
    checks++;
    if (out_valid !== 1'b1 || out_chunk !== 6'd1 || out_word !== 32'h00000100) begin
      errors++; $display("FAIL chg_word1 got v=%b c=%0d w=%h want 1/1/00000100", out_valid, out_chunk, out_word);
    end
    checks++;
    if (last_chunk !== 32'd1 || last_pos !== 32'd8) begin
      errors++; $display("FAIL chg_last got lc=%0d lp=%0d want 1/8", last_chunk, last_pos);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL chg_drain got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_predict();
    predict_mode = 1'b1;
    cmp_empty    = 1'b1;
    hit(9);
    do_flush();
    checks++;
    if (out_valid !== 1'b0 || last_pos !== 32'd8) begin
      errors++; $display("FAIL predict_suppress got v=%b lp=%0d want 0/8", out_valid, last_pos);
    end
    stop_flag = 1'b1;
    cmp_valid = 1'b1;
    #1;
    checks++;
    if (cmp_ready !== 1'b0) begin errors++; $display("FAIL stop_ready got %b want 0", cmp_ready); end
    cmp_valid = 1'b0;
    stop_flag = 1'b0;
    predict_mode = 1'b0;
    hit(9);
    do_flush();
    checks++;
    if (out_valid !== 1'b1 || out_chunk !== 6'd0 || out_word !== 32'h00000200 || last_pos !== 32'd9) begin
      errors++; $display("FAIL learn_empty got v=%b c=%0d w=%h lp=%0d want 1/0/00000200/9", out_valid, out_chunk, out_word, last_pos);
    end
    cmp_empty = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [CW+31:0] got[$];
    logic [CW+31:0] exp[5];
    logic acc;
    logic done;
    exp[0] = {6'd0, 32'h2};
    exp[1] = {6'd1, 32'h4};
    exp[2] = {6'd2, 32'h8};
    exp[3] = {6'd3, 32'h10};
    exp[4] = {6'd4, 32'h10};
    out_ready = 1'b0;
    hit(1); hit(34); hit(67);
    cmp_index = 17'd100; cmp_valid = 1'b1; cmp_fire = 1'b1;
    #1;
    checks++;
    if (cmp_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_cnt2 got %b want 1", cmp_ready); end
    tick();
    cmp_index = 17'd132;
    #1;
    checks++;
    if (cmp_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_cnt3 got %b want 0", cmp_ready); end
    repeat (3) tick();
    checks++;
    if (cmp_ready !== 1'b0 || out_chunk !== 6'd0 || out_word !== 32'h2) begin
      errors++; $display("FAIL bp_stall got r=%b c=%0d w=%h want 0/0/00000002", cmp_ready, out_chunk, out_word);
    end
    out_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !(done && !out_valid); i++) begin
      if (out_valid) got.push_back({out_chunk, out_word});
      acc = cmp_valid && cmp_ready;
      tick();
      if (acc) begin cmp_valid = 1'b0; cmp_fire = 1'b0; done = 1'b1; end
    end
    checks++;
    if (!(done && !out_valid)) begin
      errors++; $display("FAIL bp_timeout got done=%b v=%b want 1/0", done, out_valid);
      cmp_valid = 1'b0; cmp_fire = 1'b0;
    end
    do_flush();
    if (out_valid) got.push_back({out_chunk, out_word});
    tick();
    out_ready = 1'b0;
    checks++;
    if (got.size() != 5) begin errors++; $display("FAIL bp_count got %0d want 5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL bp_word%0d got %h want %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_range();
    out_ready = 1'b0;
    hit(2016);
    checks++;
    if (range_err !== 1'b1 || last_chunk !== 32'd63 || last_pos !== 32'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL range_hit got re=%b lc=%0d lp=%0d v=%b want 1/63/0/0", range_err, last_chunk, last_pos, out_valid);
    end
    hit(5);
    do_flush();
    checks++;
    if (range_err !== 1'b1 || out_valid !== 1'b1 || out_chunk !== 6'd0 || out_word !== 32'h20) begin
      errors++; $display("FAIL range_sticky got re=%b v=%b c=%0d w=%h want 1/1/0/00000020", range_err, out_valid, out_chunk, out_word);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    hit(2015);
    do_flush();
    checks++;
    if (out_valid !== 1'b1 || out_chunk !== 6'd62 || out_word !== 32'h80000000) begin
      errors++; $display("FAIL range_top got v=%b c=%0d w=%h want 1/62/80000000", out_valid, out_chunk, out_word);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    hit(10);
    rst_flag = 1'b1;
    tick();
    rst_flag = 1'b0;
    checks++;
    if (range_err !== 1'b0 || last_chunk !== 32'd0 || last_pos !== 32'd0) begin
      errors++; $display("FAIL mid_reset got re=%b lc=%0d lp=%0d want 0/0/0", range_err, last_chunk, last_pos);
    end
    do_flush();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_discard got %b want 0", out_valid); end
  endtask

  initial begin
    rst_flag     = 1'b1;
    stop_flag    = 1'b0;
    predict_mode = 1'b0;
    cmp_valid    = 1'b0;
    cmp_index    = '0;
    cmp_fire     = 1'b0;
    cmp_empty    = 1'b0;
    flush        = 1'b0;
    out_ready    = 1'b0;
    test_reset();
    test_single_chunk();
    test_chunk_change();
    test_predict();
    test_back_to_back();
    test_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
